// File: rtl/approx_add_seq_if.sv
// Handshake and operand/result bus for approx_add_seq.
// The master side is the operand producer plus result consumer.
// The slave side is the segmented adder controller.
interface approx_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             approx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             err;

    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, sum, cout, err
    );
endinterface

// File: rtl/approx_add_seq.sv
// Multi-cycle segmented adder controller.
// One 4-bit adder slice is time-shared across a WIDTH-bit add, LSB segment
// first, one segment per clock. In approximate mode each segment's carry-in
// is the generate/propagate carry of the previous segment's operands, taken
// with no carry-in. In exact mode the registered ripple carry is used.
// Optional feature macro APPROX_ERR_EN: tracks the exact ripple carry in
// parallel and raises a sticky err when a speculative carry was wrong.
// Without it, err is tied low.
module approx_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    approx_add_seq_if.slave  bus
);
    localparam int NSEG  = WIDTH / 4;
    localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("approx_add_seq: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEG_W-1:0] seg;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             approx_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             last_seg;
    logic [3:0]       a_cur;
    logic [3:0]       b_cur;
    logic [3:0]       a_prv;
    logic [3:0]       b_prv;
    logic             spec_cin;
    logic             cin;
    logic [4:0]       s;

    // Carry-out of a 4-bit add with no carry-in, as a generate/propagate chain.
    function automatic logic gen4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] g;
        logic [3:0] p;
        g = x & y;
        p = x ^ y;
        return g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & g[0])))));
    endfunction

    assign last_seg = (seg == SEG_W'(NSEG - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; ready and valid never overlap.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_seg) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the current segment's operand nibbles.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (seg == SEG_W'(k)) begin
                a_cur = a_q[4*k +: 4];
                b_cur = b_q[4*k +: 4];
            end
        end
    end

    // Select the previous segment's operand nibbles for carry speculation.
    always_comb begin
        a_prv = '0;
        b_prv = '0;
        for (int k = 1; k < NSEG; k++) begin
            if (seg == SEG_W'(k)) begin
                a_prv = a_q[4*k-4 +: 4];
                b_prv = b_q[4*k-4 +: 4];
            end
        end
    end

    // Segment 0 never has a carry-in; later segments speculate or ripple.
    always_comb begin
        spec_cin = gen4(a_prv, b_prv);
        if (seg == '0)    cin = 1'b0;
        else if (approx_q) cin = spec_cin;
        else              cin = carry_q;
        s = {1'b0, a_cur} + {1'b0, b_cur} + {4'b0000, cin};
    end

    // Operand capture and one-segment-per-cycle accumulation of the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            seg      <= '0;
            a_q      <= bus.a;
            b_q      <= bus.b;
            approx_q <= bus.approx;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else if (state == RUN) begin
            for (int k = 0; k < NSEG; k++) begin
                if (seg == SEG_W'(k)) sum_q[4*k +: 4] <= s[3:0];
            end
            carry_q <= s[4];
            if (last_seg) cout_q <= s[4];
            else          seg    <= seg + 1'b1;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef APPROX_ERR_EN
    logic       ex_c;
    logic       err_q;
    logic [4:0] ex_s;

    // True ripple sum of the current segment, independent of mode.
    assign ex_s = {1'b0, a_cur} + {1'b0, b_cur} + {4'b0000, ex_c};

    // Exact carry tracker; err latches the first wrong speculative carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_c  <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            ex_c  <= 1'b0;
            err_q <= 1'b0;
        end else if (state == RUN) begin
            ex_c <= ex_s[4];
            if (approx_q && (seg != '0) && (spec_cin != ex_c)) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_approx_add_seq.sv
// Scoreboard bench for approx_add_seq: the driver pushes reference results,
// the monitor pops and compares whenever the DUT presents a result.
module tb_approx_add_seq;
    localparam int W    = 16;
    localparam int NSEG = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_add_seq_if #(.WIDTH(W)) bus ();

    approx_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    bit   rdy_rand = 1'b0;
    logic rdy_fix  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready: fixed level or random, changed just after each edge.
    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_fix;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: segment carries from plain arithmetic on whole operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
        exp_t       e;
        logic [W:0] full;
        int         cin;
        int         cin_ex;
        int         t;
        full   = {1'b0, a} + {1'b0, b};
        e.sum  = '0;
        e.cout = 1'b0;
        e.err  = 1'b0;
        e.acc  = 0;
        for (int k = 0; k < NSEG; k++) begin
            cin_ex = (k == 0) ? 0 : int'(full[4*k] ^ a[4*k] ^ b[4*k]);
            if (k == 0)  cin = 0;
            else if (ap) cin = (int'(a[4*k-4 +: 4]) + int'(b[4*k-4 +: 4])) >> 4;
            else         cin = cin_ex;
`ifdef APPROX_ERR_EN
            if (ap && k > 0 && cin != cin_ex) e.err = 1'b1;
`endif
            t = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + cin;
            e.sum[4*k +: 4] = t[3:0];
            if (k == NSEG - 1) e.cout = t[4];
        end
        return e;
    endfunction

    // Issue one operation; called at a falling edge, returns at a falling edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                        input bit push, input bit keep, output int acc);
        exp_t e;
        int   t;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.approx   = ap;
        t = 0;
        while (!bus.in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc + 1;
        e     = model(a, b, ap);
        e.acc = acc;
        if (push) q.push_back(e);
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || have_cur) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || have_cur) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
        end
    endtask

    // Monitor: compare every cycle a result is presented, so held values are
    // also checked for stability under backpressure.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            chk("excl_ready_valid", W'(bus.in_ready), '0);
            if (!have_cur) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: sum %h with empty scoreboard", bus.sum);
                end else begin
                    cur      = q.pop_front();
                    have_cur = 1'b1;
                    chk("latency", W'(cyc - cur.acc), W'(NSEG));
                end
            end
            if (have_cur) begin
                chk("sum",  bus.sum,       cur.sum);
                chk("cout", W'(bus.cout),  W'(cur.cout));
                chk("err",  W'(bus.err),   W'(cur.err));
                if (bus.out_ready === 1'b1) have_cur = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acc;
        int acc_last;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.approx   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_sum",       bus.sum,            '0);
        chk("rst_cout",      W'(bus.cout),       '0);
        chk("rst_err",       W'(bus.err),        '0);
        chk("rst_out_valid", W'(bus.out_valid),  '0);
        rst_n   = 1'b1;
        rdy_fix = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", W'(bus.in_ready), W'(1'b1));
        @(negedge clk);

        // Directed vectors.
        send(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, acc); drain();
        send(16'h00FF, 16'h0001, 1'b1, 1'b1, 1'b0, acc); drain();
        send(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0, acc); drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, acc); drain();

        // Backpressure: hold result 5 cycles while new operands are offered.
        rdy_fix = 1'b0;
        @(negedge clk);
        send(16'h0F0F, 16'h00F1, 1'b1, 1'b1, 1'b0, acc);
        for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.approx   = 1'(i);
            @(negedge clk);
            chk("bp_in_ready",  W'(bus.in_ready),  '0);
            chk("bp_out_valid", W'(bus.out_valid), W'(1'b1));
        end
        bus.in_valid = 1'b0;
        rdy_fix      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", W'(bus.out_valid), W'(1'b1));
        @(negedge clk);
        chk("bp_post_in_ready",  W'(bus.in_ready),  W'(1'b1));
        chk("bp_post_out_valid", W'(bus.out_valid), '0);
        drain();

        // Reset in the middle of a run.
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_sum",       bus.sum,           '0);
        chk("midrst_cout",      W'(bus.cout),      '0);
        chk("midrst_err",       W'(bus.err),       '0);
        chk("midrst_out_valid", W'(bus.out_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", W'(bus.in_ready), W'(1'b1));
        send(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, acc); drain();

        // Randomized operations with random consumer backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(2) == 0) rb = ~ra ^ W'($urandom_range(3));
            send(ra, rb, 1'($urandom_range(1)), 1'b1, 1'b0, acc);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Back-to-back with in_valid held: accepts NSEG+2 edges apart.
        acc_last = 0;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), 1'(i), 1'b1, (i < 7), acc);
            if (i > 0) chk("b2b_spacing", W'(acc - acc_last), W'(NSEG + 2));
            acc_last = acc;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/approx_add_seq.md
# approx_add_seq

Multi-cycle segmented adder controller for the approximate-adder datapath. It time-shares one 4-bit adder slice across a WIDTH-bit addition, one segment per cycle, LSB first. In approximate mode each segment's carry-in is the speculative carry-generator output of the previous segment's operands, with no carry-in to that previous segment. In exact mode the true ripple carry is used. It sits between an operand producer and result consumer, using valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand/sum width; multiple of 4, minimum 8; NSEG = WIDTH/4
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- approx  input  1  1 = speculative (approximate) carry, 0 = exact ripple
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  carry-out of top segment, registered
- err  output  1  approximate result differs from exact (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Segment counter seg, 0..NSEG-1.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, approx; clear seg, sum, cout, err; go to RUN. Later changes on a/b/approx are ignored.
- RUN: in_ready=0. Each cycle, segment k=seg computes s = a_k + b_k + cin_k (4-bit, 5-bit result). sum[4k+3:4k] <= s[3:0].
- Exact carry-in: cin_0=0; cin_k = registered carry-out of segment k-1.
- Approximate carry-in: cin_0=0; cin_k = G(a_{k-1}, b_{k-1}), where G is the 4-bit generate/propagate chain with no carry-in: g3 | p3&(g2 | p2&(g1 | p1&g0)).
- On k=NSEG-1: cout <= s[4]; go to DONE. Otherwise seg <= seg+1.
- DONE: out_valid=1. sum, cout and err are held stable. On out_ready, go to IDLE. No accept in DONE (in_ready=0).
- Reset (any state, including mid-RUN): state=IDLE, seg=0, in_ready=1 after release, out_valid=0, sum=0, cout=0, err=0. Partial results are discarded.

## Timing
- Accept at edge E0. Segment k is registered at edge E(k+1). out_valid rises after E(NSEG), giving latency NSEG edges (4 for WIDTH=16).
- The result handshake completes at the first edge with out_valid&out_ready. in_ready rises the following cycle. Minimum issue interval is NSEG+2 edges.
- out_valid is never asserted in the same cycle as in_ready.
- in_valid while in_ready=0 has no effect. The producer holds in_valid and operands until accepted.
- out_ready while out_valid=0 has no effect.

## Configuration
- APPROX_ERR_EN defined:
  - An exact ripple carry register is tracked in parallel in both modes.
  - In approximate mode, err is set sticky if any segment k≥1 has speculative cin_k ≠ exact cin_k. The exact cin_k is computed against the exact lower-segment sums.
  - err is valid with out_valid and is always 0 in exact mode.
- APPROX_ERR_EN undefined: the err port remains and is tied to 0. No exact-carry register or comparison logic is present.

## Test plan
- Exact mode, WIDTH=16: a=0x00FF, b=0x0001, approx=0 → sum=0x0100, cout=0, err=0; out_valid exactly 4 edges after accept.
- Approximate mode: a=0x00FF, b=0x0001, approx=1 → sum=0x0000, cout=0, err=1 (0 without APPROX_ERR_EN).
- Approximate mode, no long chain: a=0x1234, b=0x4321 → sum=0x5555, cout=0, err=0. Exact mode: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and toggle in_valid with new operands → sum/cout/err stable, in_ready=0, new operands ignored. Releasing out_ready gives in_ready=1 one cycle after the handshake.
- Reset mid-RUN: deassert rst_n after 2 segments of a=0xFFFF, b=0xFFFF → outputs immediately 0 (async), state IDLE. After release, a=0x0001, b=0x0002 exact → sum=0x0003.
- Back-to-back ops with out_ready=1 and in_valid held → accepts spaced exactly 6 edges apart; results match a reference model in both modes.
